// File: rtl/controlador_contador_pkg.sv
// Shared types and constants for the decade-counter sequencing controller.
// Optional feature macro: CONTROLADOR_AUTO_RESTART_EN.
package contador_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [DIGIT_W-1:0] clamp_digit(
      input logic [DIGIT_W-1:0] d
   );
      return (d > MAX_DIGIT) ? MAX_DIGIT : d;
   endfunction

endpackage

// File: rtl/controlador_contador_if.sv
// Control/status bundle between the user side and the sequencing controller.
// The master side drives requests and the counter value.
interface controlador_contador_if;
   import contador_pkg::*;

   logic               start;
   logic               stop;
   logic               clear;
   logic [DIGIT_W-1:0] limit;
   logic [DIGIT_W-1:0] count_in;
   logic               cnt_en;
   logic               cnt_clr;
   logic               running;
   logic               done;
   state_t             state;

   modport master (
      output start, stop, clear, limit, count_in,
      input  cnt_en, cnt_clr, running, done, state
   );

   modport slave (
      input  start, stop, clear, limit, count_in,
      output cnt_en, cnt_clr, running, done, state
   );

endinterface

// File: rtl/controlador_contador_tick_prescaler.sv
// 8-bit prescaler: counts 0..TICK_DIV-1 while run is high, flags the last phase.
// zero overrides run; the count holds when run is low.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic zero,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (zero) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/controlador_contador.sv
// Sequencing controller for a 0-9 decade counter: start/stop/clear FSM,
// prescaled count enable, terminal-digit stop. Macro: CONTROLADOR_AUTO_RESTART_EN.
module controlador_contador
   import contador_pkg::*;
#(
   parameter int unsigned TICK_DIV = 4
) (
   input logic                   clk,
   input logic                   reset,
   controlador_contador_if.slave bus
);

   state_t state_q;
   state_t state_d;
   logic   cnt_en_q;
   logic   cnt_en_d;
   logic   cnt_clr_q;
   logic   cnt_clr_d;
   logic   running_q;
   logic   done_q;
   logic   ps_run;
   logic   ps_zero;
   logic   tick;
   logic   at_limit;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (ps_run),
      .zero  (ps_zero),
      .tick  (tick)
   );

   assign at_limit = (bus.count_in == clamp_digit(bus.limit));

   always_comb begin
      state_d   = state_q;
      cnt_en_d  = 1'b0;
      cnt_clr_d = 1'b0;
      ps_run    = 1'b0;
      ps_zero   = 1'b0;
      if (bus.clear) begin
         cnt_clr_d = 1'b1;
         ps_zero   = 1'b1;
         state_d   = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = RUN;
                  ps_zero = 1'b1;
               end
            end
            RUN: begin
               // count_in is stale while our own clear pulse is in flight
               if (bus.stop) begin
                  state_d = PAUSE;
               end else if (at_limit && !cnt_clr_q) begin
                  state_d = DONE;
`ifdef CONTROLADOR_AUTO_RESTART_EN
                  cnt_clr_d = 1'b1;
`endif
               end else begin
                  ps_run   = 1'b1;
                  cnt_en_d = tick;
               end
            end
            PAUSE: begin
               if (!bus.stop && bus.start) begin
                  state_d = RUN;
               end
            end
            DONE: begin
`ifdef CONTROLADOR_AUTO_RESTART_EN
               ps_zero = 1'b1;
               state_d = bus.stop ? PAUSE : RUN;
`else
               if (!bus.stop && bus.start) begin
                  cnt_clr_d = 1'b1;
                  ps_zero   = 1'b1;
                  state_d   = RUN;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_en_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_en_q  <= cnt_en_d;
         cnt_clr_q <= cnt_clr_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
      end
   end

   assign bus.cnt_en  = cnt_en_q;
   assign bus.cnt_clr = cnt_clr_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
   assign bus.state   = state_q;

endmodule
